ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  EX/MEM pipeline register of the MIPS pipeline. It captures execute-stage results and controls, and drives them into
//  the memory stage (branch, zero, memread, memwrite, alu_result, write_data) and onward to writeback (regwrite, memtoreg, writereg).
//  Supports stall (hold), flush (bubble insertion) and a stall-watchdog FSM, plus performance counters.
// PARAMETERS
//  DATA_W      32  width of alu_result, write_data, pcbranch
//  REG_W       5   register-file address width
//  CNT_W       32  width of performance counters
//  MAX_STALL   16  consecutive stall cycles that trip the watchdog (>=1)
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  stall          in   1       hold current contents (from hazard unit / mem_busy)
//  flush          in   1       replace next contents with a bubble
//  clr_status     in   1       synchronous clear of stall_timeout sticky flag
//  ex_valid       in   1       EX holds a real instruction
//  ex_branch, ex_zero, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  in 1 each  EX control/flags
//  ex_alu_result  in   DATA_W  ALU result / memory address
//  ex_write_data  in   DATA_W  store data
//  ex_pcbranch    in   DATA_W  branch target
//  ex_writereg    in   REG_W   destination register
//  mem_valid      out  1       MEM holds a real instruction
//  mem_branch, mem_zero, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out 1 each  registered, gated by mem_valid
//  mem_alu_result out  DATA_W  registered ex_alu_result
//  mem_write_data out  DATA_W  registered ex_write_data
//  mem_pcbranch   out  DATA_W  registered ex_pcbranch
//  mem_writereg   out  REG_W   registered ex_writereg
//  stall_count    out  CNT_W   cycles with stall=1 and flush=0 (saturating)
//  bubble_count   out  CNT_W   cycles loading a bubble: flush=1, or load with ex_valid=0 (saturating)
//  flush_count    out  CNT_W   cycles with flush=1 (saturating)
//  stall_timeout  out  1       sticky: watchdog tripped
//  reg_state      out  2       FSM state encoding
// BEHAVIOUR
//  - Reset (reset_n=0, async): every register and output = 0; FSM = RUN.
//  - Per-edge priority: flush > stall > load.
//    flush: mem_valid<=0, all six control bits<=0; data fields hold.
//    stall (no flush): all fields hold.
//    load: all fields <= ex_*; mem_valid<=ex_valid; controls <= ex_ctrl & ex_valid.
//  - Latency: 1 cycle EX->MEM. No combinational path from inputs to outputs.
//  - Control outputs are never 1 while mem_valid=0, including after flush.
//  - Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1, with no wrap.
//    Reset is the only clear.
//  - Stall-run counter (internal, clog2(MAX_STALL+1) bits): increments while in STALL/TIMEOUT with stall=1.
//    Cleared on any exit to RUN.
//  - FSM, reg_state: RUN=2'b00, STALL=2'b01, TIMEOUT=2'b10.
//    RUN -> STALL when stall & !flush; run counter <= 1.
//    STALL -> RUN when !stall or flush.
//    STALL -> TIMEOUT when stall & !flush & run==MAX_STALL; stall_timeout<=1 on the same edge.
//    TIMEOUT -> RUN when !stall or flush. Otherwise it holds.
//  - stall_timeout: sticky. Cleared only by reset or clr_status=1.
//    If clr_status and a trip occur on the same edge, the set wins.
//  - Reset mid-stall: state, run counter and contents clear immediately; the next load after release is normal.
// TESTING
//  T1 reset: drive random inputs, reset_n=0 -> all outputs 0, reg_state=00; release -> first edge loads ex_*.
//  T2 load: ex_valid=1, memwrite=1, alu_result=0x0000_0104, write_data=0xDEAD_BEEF
//     -> next cycle mem_memwrite=1, same values, mem_valid=1.
//  T3 bubble: ex_valid=0, ex_regwrite=1 -> mem_valid=0, mem_regwrite=0, bubble_count+1.
//  T4 stall then flush: load 0x40, stall 3 cycles -> outputs hold 0x40, stall_count=3, reg_state=01;
//     stall=1 & flush=1 -> mem_valid=0, reg_state=00, flush_count=1, stall_count unchanged.
//  T5 watchdog: MAX_STALL=4, hold stall=1 -> stall_timeout=1 at the 5th edge, reg_state=10.
//     Drop stall -> RUN, flag stays 1; clr_status=1 -> flag 0.
//  T6 saturation/async reset: CNT_W=4, stall 20 cycles -> stall_count=15;
//     assert reset_n mid-stall between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush handling, a stall watchdog FSM and
// saturating performance counters.
module ex_mem_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              clr_status,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [DATA_W-1:0] ex_pcbranch,
  input  logic [REG_W-1:0]  ex_writereg,
  output logic              mem_valid,
  output logic              mem_branch,
  output logic              mem_zero,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_pcbranch,
  output logic [REG_W-1:0]  mem_writereg,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              stall_timeout,
  output logic [1:0]        reg_state
);

  localparam int unsigned RunW = $clog2(MAX_STALL + 1);
  localparam logic [RunW-1:0]  RunOne = RunW'(1);
  localparam logic [RunW-1:0]  RunMax = RunW'(MAX_STALL);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StStall   = 2'b01,
    StTimeout = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              valid_q, valid_d;
  logic [5:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] pcb_q, pcb_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;

  logic       load;
  logic [5:0] ex_ctrl;

  assign load    = !flush && !stall;
  assign ex_ctrl = {ex_branch, ex_zero, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  // Pipeline contents and counters
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    pcb_d        = pcb_q;
    wreg_d       = wreg_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = ex_valid;
      ctrl_d  = ex_ctrl & {6{ex_valid}};
      alu_d   = ex_alu_result;
      wdata_d = ex_write_data;
      pcb_d   = ex_pcbranch;
      wreg_d  = ex_writereg;
    end

    if (stall && !flush)         stall_cnt_d  = sat_inc(stall_cnt_q);
    if (flush || (load && !ex_valid)) bubble_cnt_d = sat_inc(bubble_cnt_q);
    if (flush)                   flush_cnt_d  = sat_inc(flush_cnt_q);
  end

  // Watchdog FSM; a trip on the same edge as clr_status leaves the flag set.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    timeout_d = timeout_q && !clr_status;

    unique case (state_q)
      StRun: begin
        if (stall && !flush) begin
          state_d = StStall;
          run_d   = RunOne;
        end
      end
      StStall: begin
        if (!stall || flush) begin
          state_d = StRun;
          run_d   = '0;
        end else if (run_q == RunMax) begin
          state_d   = StTimeout;
          timeout_d = 1'b1;
        end else begin
          run_d = run_q + RunOne;
        end
      end
      StTimeout: begin
        if (!stall || flush) begin
          state_d = StRun;
          run_d   = '0;
        end else if (run_q != RunMax) begin
          run_d = run_q + RunOne;
        end
      end
      default: begin
        state_d = StRun;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      run_q        <= '0;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      pcb_q        <= '0;
      wreg_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      pcb_q        <= pcb_d;
      wreg_q       <= wreg_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Gating by valid_q is redundant with the load path but guarantees no stray controls.
  assign mem_valid      = valid_q;
  assign mem_branch     = ctrl_q[5] & valid_q;
  assign mem_zero       = ctrl_q[4] & valid_q;
  assign mem_memread    = ctrl_q[3] & valid_q;
  assign mem_memwrite   = ctrl_q[2] & valid_q;
  assign mem_regwrite   = ctrl_q[1] & valid_q;
  assign mem_memtoreg   = ctrl_q[0] & valid_q;
  assign mem_alu_result = alu_q;
  assign mem_write_data = wdata_q;
  assign mem_pcbranch   = pcb_q;
  assign mem_writereg   = wreg_q;
  assign stall_count    = stall_cnt_q;
  assign bubble_count   = bubble_cnt_q;
  assign flush_count    = flush_cnt_q;
  assign stall_timeout  = timeout_q;
  assign reg_state      = state_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, load, bubble, stall/flush, watchdog,
// counter saturation and asynchronous reset mid-stall.
module tb_ex_mem_reg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_STALL = 4;

  logic              clk, reset_n, stall, flush, clr_status, ex_valid;
  logic              ex_branch, ex_zero, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [DATA_W-1:0] ex_alu_result, ex_write_data, ex_pcbranch;
  logic [REG_W-1:0]  ex_writereg;
  logic              mem_valid;
  logic              mem_branch, mem_zero, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic [DATA_W-1:0] mem_alu_result, mem_write_data, mem_pcbranch;
  logic [REG_W-1:0]  mem_writereg;
  logic [CNT_W-1:0]  stall_count, bubble_count, flush_count;
  logic              stall_timeout;
  logic [1:0]        reg_state;
  logic [5:0]        mem_ctrl;

  int n_total = 0;
  int n_bad   = 0;

  assign mem_ctrl = {mem_branch, mem_zero, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg};

  ex_mem_reg #(
    .DATA_W   (DATA_W),
    .REG_W    (REG_W),
    .CNT_W    (CNT_W),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .flush         (flush),
    .clr_status    (clr_status),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_zero       (ex_zero),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_regwrite   (ex_regwrite),
    .ex_memtoreg   (ex_memtoreg),
    .ex_alu_result (ex_alu_result),
    .ex_write_data (ex_write_data),
    .ex_pcbranch   (ex_pcbranch),
    .ex_writereg   (ex_writereg),
    .mem_valid     (mem_valid),
    .mem_branch    (mem_branch),
    .mem_zero      (mem_zero),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_regwrite  (mem_regwrite),
    .mem_memtoreg  (mem_memtoreg),
    .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data),
    .mem_pcbranch  (mem_pcbranch),
    .mem_writereg  (mem_writereg),
    .stall_count   (stall_count),
    .bubble_count  (bubble_count),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout),
    .reg_state     (reg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [5:0] c, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] pcb, input logic [4:0] wr);
    ex_valid = v;
    {ex_branch, ex_zero, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg} = c;
    ex_alu_result = alu;
    ex_write_data = wd;
    ex_pcbranch   = pcb;
    ex_writereg   = wr;
  endtask

  initial begin
    // T1: reset with busy inputs
    reset_n    = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    clr_status = 1'b0;
    set_ex(1'b1, 6'h3F, $urandom, $urandom, $urandom, 5'($urandom));
    #23;
    chk("rst_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_ctrl", {58'd0, mem_ctrl}, 64'd0);
    chk("rst_alu", {32'd0, mem_alu_result}, 64'd0);
    chk("rst_wdata", {32'd0, mem_write_data}, 64'd0);
    chk("rst_cnts", {52'd0, stall_count, bubble_count, flush_count}, 64'd0);
    chk("rst_state", {61'd0, stall_timeout, reg_state}, 64'd0);
    reset_n = 1'b1;
    set_ex(1'b1, 6'h3F, 32'h1234_5678, 32'hCAFE_F00D, 32'h0040_0020, 5'd7);
    tick();
    chk("t1_valid", {63'd0, mem_valid}, 64'd1);
    chk("t1_ctrl", {58'd0, mem_ctrl}, 64'h3F);
    chk("t1_alu", {32'd0, mem_alu_result}, 64'h1234_5678);
    chk("t1_pcb", {32'd0, mem_pcbranch}, 64'h0040_0020);
    chk("t1_wreg", {59'd0, mem_writereg}, 64'd7);

    // T2: store
    set_ex(1'b1, 6'b000100, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 5'd0);
    tick();
    chk("t2_valid", {63'd0, mem_valid}, 64'd1);
    chk("t2_ctrl", {58'd0, mem_ctrl}, 64'b000100);
    chk("t2_alu", {32'd0, mem_alu_result}, 64'h104);
    chk("t2_wdata", {32'd0, mem_write_data}, 64'hDEAD_BEEF);

    // T3: bubble via ex_valid=0
    set_ex(1'b0, 6'b000010, 32'h0000_0200, 32'h11, 32'h0, 5'd3);
    tick();
    chk("t3_valid", {63'd0, mem_valid}, 64'd0);
    chk("t3_regwrite", {63'd0, mem_regwrite}, 64'd0);
    chk("t3_bubble", {60'd0, bubble_count}, 64'd1);
    chk("t3_alu", {32'd0, mem_alu_result}, 64'h200);

    // T4: load 0x40, stall 3, then stall+flush
    set_ex(1'b1, 6'b000010, 32'h40, 32'h77, 32'h0, 5'd9);
    tick();
    stall = 1'b1;
    set_ex(1'b1, 6'h3F, 32'h99, 32'h88, 32'h0, 5'd1);
    tick();
    tick();
    tick();
    chk("t4_hold_alu", {32'd0, mem_alu_result}, 64'h40);
    chk("t4_hold_ctrl", {57'd0, mem_valid, mem_ctrl}, 64'b1000010);
    chk("t4_stall_cnt", {60'd0, stall_count}, 64'd3);
    chk("t4_state", {62'd0, reg_state}, 64'b01);
    flush = 1'b1;
    tick();
    chk("t4f_valid", {63'd0, mem_valid}, 64'd0);
    chk("t4f_ctrl", {58'd0, mem_ctrl}, 64'd0);
    chk("t4f_state", {62'd0, reg_state}, 64'b00);
    chk("t4f_flush_cnt", {60'd0, flush_count}, 64'd1);
    chk("t4f_stall_cnt", {60'd0, stall_count}, 64'd3);
    chk("t4f_bubble", {60'd0, bubble_count}, 64'd2);
    chk("t4f_alu_hold", {32'd0, mem_alu_result}, 64'h40);

    // T5: watchdog trips on 5th stall edge with MAX_STALL=4
    flush = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pre_state", {62'd0, reg_state}, 64'b01);
    chk("t5_pre_flag", {63'd0, stall_timeout}, 64'd0);
    tick();
    chk("t5_trip_state", {62'd0, reg_state}, 64'b10);
    chk("t5_trip_flag", {63'd0, stall_timeout}, 64'd1);
    chk("t5_stall_cnt", {60'd0, stall_count}, 64'd8);
    stall = 1'b0;
    tick();
    chk("t5_run_state", {62'd0, reg_state}, 64'b00);
    chk("t5_sticky", {63'd0, stall_timeout}, 64'd1);
    chk("t5_load_alu", {32'd0, mem_alu_result}, 64'h99);
    clr_status = 1'b1;
    tick();
    chk("t5_clr", {63'd0, stall_timeout}, 64'd0);
    clr_status = 1'b0;

    // T6: long stall, trip coinciding with clr_status, saturation, async reset
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      clr_status = (i == 5);
      tick();
      if (i == 5) chk("t6_set_wins", {61'd0, stall_timeout, reg_state}, 64'b110);
    end
    clr_status = 1'b0;
    chk("t6_sat", {60'd0, stall_count}, 64'd15);
    chk("t6_state", {61'd0, stall_timeout, reg_state}, 64'b110);
    chk("t6_alu_hold", {32'd0, mem_alu_result}, 64'h99);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_arst_alu", {32'd0, mem_alu_result}, 64'd0);
    chk("t6_arst_valid", {57'd0, mem_valid, mem_ctrl}, 64'd0);
    chk("t6_arst_cnts", {52'd0, stall_count, bubble_count, flush_count}, 64'd0);
    chk("t6_arst_state", {61'd0, stall_timeout, reg_state}, 64'd0);
    #1;
    reset_n = 1'b1;
    stall   = 1'b0;
    set_ex(1'b1, 6'b000001, 32'h55, 32'h66, 32'h0, 5'd4);
    tick();
    chk("t6_post_alu", {32'd0, mem_alu_result}, 64'h55);
    chk("t6_post_ctrl", {57'd0, mem_valid, mem_ctrl}, 64'b1000001);
    chk("t6_post_state", {58'd0, reg_state, stall_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
